apb_master_bridge: RTL
======================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles to wait for PREADY; 0 disables the timeout.
REQ-002 Parameter ADDR_MAX, default 32'h0000_FFFF: highest legal address; commands above it never reach the bus.
REQ-003 PCLK  input  1  APB clock; all logic is on the rising edge.
REQ-004 PRESET  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request from the local requester.
REQ-006 cmd_ready  output  1  bridge accepts a command; high only in IDLE.
REQ-007 cmd_write  input  1  command direction: 1 = write, 0 = read.
REQ-008 cmd_addr  input  32  command address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester accepts the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  PSLVERR, address-range error or timeout.
REQ-014 rsp_timeout  output  1  the error was caused by a timeout.
REQ-015 PADDR  output  32  APB address.
REQ-016 PWDATA  output  32  APB write data.
REQ-017 PWRITE  output  1  APB direction.
REQ-018 PSEL  output  1  APB select.
REQ-019 PENABLE  output  1  APB enable.
REQ-020 PRDATA  input  32  APB read data.
REQ-021 PREADY  input  1  APB completer ready.
REQ-022 PSLVERR  input  1  APB completer error.

Function
REQ-023 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP, and all APB and response outputs SHALL be registered.
REQ-024 In IDLE, a handshake occurs when cmd_valid=1 and cmd_ready=1; the bridge latches cmd_write, cmd_addr and cmd_wdata on that edge.
REQ-025 If the accepted address is within range (cmd_addr <= ADDR_MAX), the next state is SETUP; otherwise it is RESP with rsp_err=1 and rsp_timeout=0, and PSEL never asserts.
REQ-026 In SETUP, the outputs are PSEL=1 and PENABLE=0, with PADDR, PWRITE and PWDATA driven from the latched values; SETUP lasts exactly one cycle and is always followed by ACCESS.
REQ-027 In ACCESS, the outputs are PSEL=1 and PENABLE=1, and PADDR, PWRITE and PWDATA SHALL remain stable until exit.
REQ-028 On an ACCESS cycle with PREADY=1, the bridge captures rsp_rdata=PRDATA (reads only; 0 for writes), sets rsp_err=PSLVERR and rsp_timeout=0, deasserts PSEL and PENABLE on the next edge, and moves to RESP.
REQ-029 The wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
REQ-030 The counter width SHALL hold TIMEOUT_CYCLES without wrap.
REQ-031 When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 while PREADY=0, the bridge aborts: PSEL and PENABLE go to 0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, and the next state is RESP.
REQ-032 If PREADY=1 on the same cycle the timeout would expire, PREADY takes priority.
REQ-033 In RESP, rsp_valid=1 and the response fields are held until rsp_valid=1 and rsp_ready=1; the bridge then returns to IDLE and rsp_valid clears on the next edge.
REQ-034 cmd_ready is 0 in SETUP, ACCESS and RESP, so at most one transfer is outstanding.
REQ-035 Minimum command-to-command spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP) with zero wait states and rsp_ready held high.
REQ-036 PENABLE is never 1 while PSEL is 0, and it never asserts in the first cycle of PSEL.
REQ-037 Outside SETUP and ACCESS, PADDR, PWDATA and PWRITE hold their last values.

Reset
REQ-038 While PRESET=0, all of the following are forced asynchronously: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, and the wait counter=0.
REQ-039 While PRESET=0, cmd_ready SHALL be 0, and it rises in the first cycle after reset release.
REQ-040 A reset during SETUP, ACCESS or RESP abandons the transfer and produces no response.

Structure
REQ-041 Package apb_pkg SHALL hold the apb_state_e enum (IDLE, SETUP, ACCESS, RESP), APB_ADDR_W=32 and APB_DATA_W=32.
REQ-042 The wait counter and timeout compare SHALL be a single sub-module, apb_watchdog, with inputs clear, count_en and limit and output expired.

Verification
REQ-043 Zero-wait write: write to 0x10 with data 0xDEADBEEF and PREADY=1 in the first ACCESS cycle -> PSEL high 2 cycles, PENABLE high 1 cycle, PADDR=0x10, PWDATA=0xDEADBEEF, and rsp_valid=1 with rsp_err=0 one cycle later.
REQ-044 Wait-state read: read from 0x20 with PREADY low for 3 cycles, then high with PRDATA=0xA5A5_0001 -> ACCESS lasts 4 cycles, PADDR is stable throughout, rsp_rdata=0xA5A5_0001, rsp_err=0.
REQ-045 Timeout: TIMEOUT_CYCLES=4 and PREADY held at 0 -> PSEL drops after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; also, PREADY=1 on the 4th cycle -> normal completion with rsp_timeout=0.
REQ-046 Range error and PSLVERR: cmd_addr=0x0001_0000 with the default ADDR_MAX -> PSEL never asserts, rsp_err=1; a read answered with PSLVERR=1 -> rsp_err=1 and rsp_timeout=0.
REQ-047 Backpressure: rsp_ready held at 0 for 5 cycles -> rsp_valid and all response fields stable and cmd_ready=0; after the rsp_ready handshake, cmd_ready=1 on the next cycle.
REQ-048 Reset mid-ACCESS: PRESET pulled low during a wait state -> PSEL, PENABLE and rsp_valid go to 0 immediately, and no response is issued after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB master bridge and its watchdog.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Smallest counter width that can hold n without wrapping (never below 1).
    function automatic int unsigned wd_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// Wait-state counter for the ACCESS phase; flags the cycle on which the
// configured limit is reached. A zero limit never expires.
module apb_watchdog #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             clear,
    input  logic             count_en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (limit != '0) && (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from a valid/ready command port to an APB
// completer, with address-range check and wait-state timeout.
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
// RESP   | rsp_valid held until the requester takes it
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned           TIMEOUT_CYCLES = 16,
    parameter logic [APB_ADDR_W-1:0] ADDR_MAX       = 32'h0000_FFFF
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [APB_ADDR_W-1:0] PADDR,
    output logic [APB_DATA_W-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned      CNT_W = wd_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    apb_state_e state;
    logic       wd_clear;
    logic       wd_count_en;
    logic       wd_expired;

    assign wd_clear    = (state == SETUP);
    assign wd_count_en = (state == ACCESS) && !PREADY;

    apb_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .limit    (LIMIT),
        .expired  (wd_expired)
    );

    // PADDR/PWDATA/PWRITE double as the command latch; an out-of-range
    // command never touches them so the bus keeps its last values.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_addr <= ADDR_MAX) begin
                            state  <= SETUP;
                            PSEL   <= 1'b1;
                            PWRITE <= cmd_write;
                            PADDR  <= cmd_addr;
                            PWDATA <= cmd_wdata;
                        end else begin
                            state       <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state       <= RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (PWRITE || PSLVERR) ? '0 : PRDATA;
                    end else if (wd_expired) begin
                        state       <= RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
